// File: rtl/roe_pkg.sv
// rtl/roe_pkg.sv - shared constants and types for the R.O.E register file
package roe_pkg;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic {CLR_IDLE, CLR_ACTIVE} clr_state_t;

endpackage

// File: rtl/regfile_clear_fsm.sv
// rtl/regfile_clear_fsm.sv - bulk-clear sequencer: walks every register address once
module regfile_clear_fsm
    import roe_pkg::*;
#(
    parameter int NREGS = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr_req,
    output logic                      busy,
    output logic                      clr_start,
    output logic [$clog2(NREGS)-1:0]  clr_addr
);

    localparam int AW = $clog2(NREGS);
    localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);

    clr_state_t     state, state_next;
    logic [AW:0]    cnt, cnt_next;

    // State and counter register; reset drops straight back to idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLR_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic; requests arriving while clearing are ignored
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy       = 1'b0;
        clr_start  = 1'b0;
        clr_addr   = cnt[AW-1:0];
        case (state)
            CLR_IDLE: begin
                if (clr_req) begin
                    state_next = CLR_ACTIVE;
                    cnt_next   = '0;
                    clr_start  = 1'b1;
                end
            end
            CLR_ACTIVE: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = CLR_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + (AW+1)'(1);
                end
            end
            default: state_next = CLR_IDLE;
        endcase
    end

endmodule

// File: rtl/reg_file.sv
// rtl/reg_file.sv - 2R1W register file with overflow flag and bulk clear (optional REGFILE_BYPASS_EN)
module reg_file
    import roe_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] raddr0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ov_we,
    input  logic              ov_in,
    output logic              ov_o,
    input  logic              clr_req,
    output logic              busy
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              clr_start;
    logic [ADDR_W-1:0] clr_addr;
    logic              write_ok;

    regfile_clear_fsm #(.NREGS(NUM_REGS)) u_clear_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req),
        .busy      (busy),
        .clr_start (clr_start),
        .clr_addr  (clr_addr)
    );

    // A write is dropped while clearing and in the cycle a clear is accepted
    assign write_ok = we && !busy && !clr_start;

    // Storage: clear sequencer has priority over the write-back port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (busy) begin
            regs[clr_addr] <= '0;
        end else if (write_ok) begin
            regs[waddr] <= wdata;
        end
    end

    // Overflow flag: zeroed when a clear starts, frozen while clearing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_o <= 1'b0;
        end else if (clr_start) begin
            ov_o <= 1'b0;
        end else if (ov_we && !busy) begin
            ov_o <= ov_in;
        end
    end

    // Combinational read ports, with optional write-through bypass
    always_comb begin
        rdata0 = regs[raddr0];
        rdata1 = regs[raddr1];
`ifdef REGFILE_BYPASS_EN
        if (write_ok && raddr0 == waddr) rdata0 = wdata;
        if (write_ok && raddr1 == waddr) rdata1 = wdata;
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - scoreboard bench for reg_file
module tb_reg_file;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] raddr0, raddr1, waddr;
    logic [7:0] rdata0, rdata1, wdata;
    logic       we, ov_we, ov_in, ov_o, clr_req, busy;

    reg_file dut (
        .clk(clk), .rst_n(rst_n),
        .raddr0(raddr0), .raddr1(raddr1), .rdata0(rdata0), .rdata1(rdata1),
        .we(we), .waddr(waddr), .wdata(wdata),
        .ov_we(ov_we), .ov_in(ov_in), .ov_o(ov_o),
        .clr_req(clr_req), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        logic       ov;
        logic       bsy;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mregs [16];
    logic       mov, mbusy;
    int         mcnt;
    int         n_checks = 0;
    int         n_pass   = 0;
    int         busy_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mov = 1'b0; mbusy = 1'b0; mcnt = 0;
        sb.delete();
    endtask

    // One clock: drive, push expectation, compare at negedge, advance model at posedge
    task automatic step(input logic we_i, input logic [3:0] wa, input logic [7:0] wd,
                        input logic ovwe_i, input logic ovin_i, input logic clr_i,
                        input logic [3:0] ra0, input logic [3:0] ra1);
        exp_t e;
        logic wok;
        we = we_i; waddr = wa; wdata = wd; ov_we = ovwe_i; ov_in = ovin_i;
        clr_req = clr_i; raddr0 = ra0; raddr1 = ra1;
        wok = we_i && !mbusy && !clr_i;
        e.d0 = mregs[ra0]; e.d1 = mregs[ra1]; e.ov = mov; e.bsy = mbusy;
`ifdef REGFILE_BYPASS_EN
        if (wok && ra0 == wa) e.d0 = wd;
        if (wok && ra1 == wa) e.d1 = wd;
`endif
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("rdata0", {24'h0, rdata0}, {24'h0, e.d0});
            check("rdata1", {24'h0, rdata1}, {24'h0, e.d1});
            check("ov_o", {31'h0, ov_o}, {31'h0, e.ov});
            check("busy", {31'h0, busy}, {31'h0, e.bsy});
        end
        if (busy === 1'b1) busy_seen++;
        @(posedge clk);
        if (mbusy) begin
            mregs[mcnt] = 8'h00;
            if (mcnt == 15) begin mbusy = 1'b0; mcnt = 0; end
            else mcnt++;
        end else if (clr_i) begin
            mbusy = 1'b1; mcnt = 0; mov = 1'b0;
        end else begin
            if (we_i) mregs[wa] = wd;
            if (ovwe_i) mov = ovin_i;
        end
        #1;
    endtask

    task automatic idle_read(input logic [3:0] a0, input logic [3:0] a1);
        step(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, a0, a1);
    endtask

    task automatic fill();
        for (int i = 0; i < 16; i++)
            step(1'b1, 4'(i), 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, 4'(i), 4'(15 - i));
    endtask

    initial begin
        rst_n = 1'b0; we = 0; waddr = 0; wdata = 0; ov_we = 0; ov_in = 0;
        clr_req = 0; raddr0 = 0; raddr1 = 0;
        model_reset();
        #12;
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_ov", {31'h0, ov_o}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: all registers zero after reset
        for (int i = 0; i < 16; i++) idle_read(4'(i), 4'(15 - i));

        // 2: write r3 and read it in the same and next cycle
        step(1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3);
        idle_read(4'd3, 4'd3);

        // 3: fill, then clear with a colliding write to r2
        fill();
        busy_seen = 0;
        step(1'b1, 4'd2, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd2, 4'd5);
        for (int i = 0; i < 16; i++) idle_read(4'd5, 4'(i));
        idle_read(4'd2, 4'd5);
        check("clr_busy_cycles", busy_seen, 16);
        for (int i = 0; i < 16; i++) idle_read(4'(i), 4'(15 - i));

        // 4: re-request and flag writes during a clear are ignored
        step(1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1);
        fill();
        busy_seen = 0;
        step(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1);
        for (int i = 0; i < 16; i++)
            step(1'b1, 4'd7, 8'h77, 1'b1, 1'b1, (i == 3 || i == 10), 4'd7, 4'(i));
        for (int i = 0; i < 3; i++) idle_read(4'd7, 4'd0);
        check("reclr_busy_cycles", busy_seen, 16);

        // 5: asynchronous reset in clear cycle 7
        fill();
        step(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 4'd15);
        for (int i = 0; i < 6; i++) idle_read(4'd15, 4'd10);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'h0, busy}, 0);
        check("arst_r15", {24'h0, rdata0}, 0);
        check("arst_r10", {24'h0, rdata1}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) idle_read(4'(i), 4'(15 - i));

        // 6: overflow flag set then held
        step(1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
        step(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
        idle_read(4'd0, 4'd0);
        check("ov_held", {31'h0, ov_o}, 1);

        // top address write and dual-port same-address read
        step(1'b1, 4'd15, 8'h3C, 1'b0, 1'b0, 1'b0, 4'd15, 4'd14);
        idle_read(4'd15, 4'd15);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
